iob2axil: RTL and testbench
===========================

IOB2AXIL -- requirements
Module: iob2axil

Interface
REQ-001 SHALL have parameter AXIL_ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter AXIL_DATA_W, default 32, data width in bits (multiple of 8).
REQ-003 SHALL have clk  input  1  the single clock; every register is updated on the rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have valid  input  1  native request valid, held by the master until ready.
REQ-006 SHALL have addr  input  AXIL_ADDR_W  native request address.
REQ-007 SHALL have wdata  input  AXIL_DATA_W  native write data.
REQ-008 SHALL have wstrb  input  AXIL_DATA_W/8  native byte strobes; nonzero means write, zero means read.
REQ-009 SHALL have rdata  output  AXIL_DATA_W  native read data, valid while ready is high after a read.
REQ-010 SHALL have ready  output  1  native completion, a one-cycle pulse per request.
REQ-011 SHALL have m_axil_awaddr  output  AXIL_ADDR_W  write address.
REQ-012 SHALL have m_axil_awvalid  output  1  write address valid.
REQ-013 SHALL have m_axil_awready  input  1  write address ready.
REQ-014 SHALL have m_axil_wdata  output  AXIL_DATA_W  write data.
REQ-015 SHALL have m_axil_wstrb  output  AXIL_DATA_W/8  write strobes.
REQ-016 SHALL have m_axil_wvalid  output  1  write data valid.
REQ-017 SHALL have m_axil_wready  input  1  write data ready.
REQ-018 SHALL have m_axil_bresp  input  2  write response, ignored.
REQ-019 SHALL have m_axil_bvalid  input  1  write response valid.
REQ-020 SHALL have m_axil_bready  output  1  write response ready.
REQ-021 SHALL have m_axil_araddr  output  AXIL_ADDR_W  read address.
REQ-022 SHALL have m_axil_arvalid  output  1  read address valid.
REQ-023 SHALL have m_axil_arready  input  1  read address ready.
REQ-024 SHALL have m_axil_rdata  input  AXIL_DATA_W  read data.
REQ-025 SHALL have m_axil_rresp  input  2  read response, ignored.
REQ-026 SHALL have m_axil_rvalid  input  1  read data valid.
REQ-027 SHALL have m_axil_rready  output  1  read data ready.

Function
REQ-028 SHALL implement the FSM states IDLE, WADDR, WRESP, RADDR, RRESP and DONE, with one native request in flight at most.
REQ-029 SHALL, in IDLE with valid=1, capture addr, wdata and wstrb into registers and go to WADDR if wstrb!=0, otherwise to RADDR.
REQ-030 SHALL drive every AXI address, data and strobe output from the captured registers, never directly from the native inputs.
REQ-031 SHALL, on entering WADDR, assert awvalid and wvalid together; each SHALL drop independently in the cycle after its own valid&ready handshake.
REQ-032 SHALL remain in WADDR until both the AW and W handshakes have occurred, in either order or in the same cycle, then go to WRESP.
REQ-033 SHALL assert bready only in WRESP and SHALL go to DONE on bvalid=1.
REQ-034 SHALL, on entering RADDR, assert arvalid, and SHALL go to RRESP in the cycle after the arvalid&arready handshake.
REQ-035 SHALL assert rready only in RRESP and, on rvalid=1, SHALL capture m_axil_rdata into rdata and go to DONE.
REQ-036 SHALL hold rdata until the next read capture; writes SHALL NOT alter rdata.
REQ-037 SHALL assert ready=1 only in DONE, for exactly one cycle, and DONE SHALL always return to IDLE.
REQ-038 SHALL NOT deassert any AXI valid before its handshake, and SHALL NOT let any AXI valid depend combinationally on the matching ready.
REQ-039 SHALL ignore bresp and rresp: an error response still completes the request with ready=1.
REQ-040 SHALL, with awready, wready and bvalid held high, give the write latency: valid sampled at edge t, AW and W handshakes in cycle t+1, B in cycle t+2, ready in cycle t+3.
REQ-041 SHALL ignore valid in every state except IDLE, and SHALL accept a new valid in IDLE in the cycle right after DONE (back-to-back).

Reset
REQ-042 SHALL, while rst_n=0, hold state=IDLE, every AXI valid and ready output=0, ready=0, and all captured registers and rdata=0.
REQ-043 SHALL, if rst_n asserts mid-transaction, abandon the request immediately with no ready pulse.

Verification
REQ-044 SHALL cover a write with addr=0x10, wdata=0xDEADBEEF, wstrb=0xF and all AXI readies high -> awaddr=0x10, wdata=0xDEADBEEF, ready in cycle t+3.
REQ-045 SHALL cover a read with addr=0x20, wstrb=0 and the slave returning rdata=0x12345678 after 3 wait cycles on arready -> rdata=0x12345678 while ready=1, and arvalid held throughout the stall.
REQ-046 SHALL cover a write with wready 4 cycles later than awready -> awvalid drops after its handshake, wvalid stays high, and exactly one B is accepted.
REQ-047 SHALL cover a write with bresp=2'b10 -> ready still pulses once, and a following read returns the correct data.
REQ-048 SHALL cover back-to-back write then read -> no lost request and exactly two ready pulses.
REQ-049 SHALL cover rst_n=0 asserted during RRESP -> all outputs 0 at once, no ready, and the next request completes normally.

Source files
------------

// File: rtl/iob2axil.sv
// Native valid/ready request port to AXI4-Lite master bridge.
// One request in flight; all AXI outputs come from captured registers.
module iob2axil #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid,
  input  logic [AXIL_ADDR_W-1:0]   addr,
  input  logic [AXIL_DATA_W-1:0]   wdata,
  input  logic [AXIL_DATA_W/8-1:0] wstrb,
  output logic [AXIL_DATA_W-1:0]   rdata,
  output logic                     ready,
  output logic [AXIL_ADDR_W-1:0]   m_axil_awaddr,
  output logic                     m_axil_awvalid,
  input  logic                     m_axil_awready,
  output logic [AXIL_DATA_W-1:0]   m_axil_wdata,
  output logic [AXIL_DATA_W/8-1:0] m_axil_wstrb,
  output logic                     m_axil_wvalid,
  input  logic                     m_axil_wready,
  input  logic [1:0]               m_axil_bresp,
  input  logic                     m_axil_bvalid,
  output logic                     m_axil_bready,
  output logic [AXIL_ADDR_W-1:0]   m_axil_araddr,
  output logic                     m_axil_arvalid,
  input  logic                     m_axil_arready,
  input  logic [AXIL_DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]               m_axil_rresp,
  input  logic                     m_axil_rvalid,
  output logic                     m_axil_rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP, DONE} state_t;

  state_t                   state;
  logic [AXIL_ADDR_W-1:0]   addr_q;
  logic [AXIL_DATA_W-1:0]   wdata_q;
  logic [AXIL_DATA_W/8-1:0] wstrb_q;
  logic                     aw_done;
  logic                     w_done;
  logic                     unused_resp;

  // Responses complete the request regardless of their error code.
  assign unused_resp = ^{m_axil_bresp, m_axil_rresp};

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;

  // A channel is finished once its valid has dropped or handshakes this cycle.
  assign aw_done = !m_axil_awvalid || m_axil_awready;
  assign w_done  = !m_axil_wvalid  || m_axil_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      rdata          <= '0;
      ready          <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            if (wstrb != '0) begin
              state          <= WADDR;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
            end else begin
              state          <= RADDR;
              m_axil_arvalid <= 1'b1;
            end
          end
        end
        WADDR: begin
          if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            state         <= WRESP;
            m_axil_bready <= 1'b1;
          end
        end
        WRESP: begin
          if (m_axil_bvalid) begin
            state         <= DONE;
            m_axil_bready <= 1'b0;
            ready         <= 1'b1;
          end
        end
        RADDR: begin
          if (m_axil_arready) begin
            state          <= RRESP;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
          end
        end
        RRESP: begin
          if (m_axil_rvalid) begin
            state         <= DONE;
            rdata         <= m_axil_rdata;
            m_axil_rready <= 1'b0;
            ready         <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob2axil.sv
// Self-checking bench for iob2axil: AXI-Lite slave model with programmable
// stalls, reference word memory, and directed plus randomized requests.
module tb_iob2axil;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] m_axil_awaddr;
  logic        m_axil_awvalid;
  logic        m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid;
  logic        m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;

  int checks = 0;
  int errors = 0;

  iob2axil #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata),
    .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready), .m_axil_rdata(m_axil_rdata),
    .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready)
  );

  always #5 clk = ~clk;

  // slave configuration
  int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  // slave state
  logic [31:0] smem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] rq [$];
  int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, pend_b;
  bit  aw_hs, w_hs, ar_hs, aw_hold, w_hold, ar_hold, b_hs, r_hs, aw_got, w_got;
  logic [31:0] got_awaddr, got_wdata, last_awaddr, last_wdata;
  logic [3:0]  got_wstrb, last_wstrb;
  int  b_count = 0;
  int  ready_cnt = 0;
  bit  prev_ready = 0;
  logic [31:0] exp_rdata = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] s_read(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  // AXI-Lite slave model; acts once per cycle on the falling edge.
  initial begin
    m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 0;
    m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rresp = 0; m_axil_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0;
        m_axil_arready = 0; m_axil_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; pend_b = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; aw_hold = 0; w_hold = 0; ar_hold = 0;
        b_hs = 0; r_hs = 0; aw_got = 0; w_got = 0;
        rq.delete();
        continue;
      end
      if (b_hs) begin m_axil_bvalid = 0; b_hs = 0; end
      if (r_hs) begin m_axil_rvalid = 0; r_hs = 0; end
      if (aw_hold) begin checks++;
        if (m_axil_awvalid !== 1'b1) begin errors++; $display("FAIL awvalid_hold: got %b need 1", m_axil_awvalid); end end
      if (w_hold) begin checks++;
        if (m_axil_wvalid !== 1'b1) begin errors++; $display("FAIL wvalid_hold: got %b need 1", m_axil_wvalid); end end
      if (ar_hold) begin checks++;
        if (m_axil_arvalid !== 1'b1) begin errors++; $display("FAIL arvalid_hold: got %b need 1", m_axil_arvalid); end end
      if (aw_hs) begin checks++;
        if (m_axil_awvalid !== 1'b0) begin errors++; $display("FAIL awvalid_drop: got %b need 0", m_axil_awvalid); end end
      if (w_hs) begin checks++;
        if (m_axil_wvalid !== 1'b0) begin errors++; $display("FAIL wvalid_drop: got %b need 0", m_axil_wvalid); end end
      if (ar_hs) begin checks++;
        if (m_axil_arvalid !== 1'b0) begin errors++; $display("FAIL arvalid_drop: got %b need 0", m_axil_arvalid); end end
      // responses are launched only in cycles after their address handshakes
      if (pend_b > 0 && !m_axil_bvalid) begin
        if (b_cnt >= b_delay) begin m_axil_bvalid = 1; m_axil_bresp = bresp_cfg; b_cnt = 0; end
        else b_cnt++;
      end
      if (rq.size() > 0 && !m_axil_rvalid) begin
        if (r_cnt >= r_delay) begin
          m_axil_rvalid = 1; m_axil_rdata = s_read(rq[0]); m_axil_rresp = rresp_cfg; r_cnt = 0;
        end else begin
          r_cnt++; m_axil_rdata = $urandom;
        end
      end else if (!m_axil_rvalid) m_axil_rdata = $urandom;
      m_axil_awready = 0; aw_hs = 0; aw_hold = 0;
      if (m_axil_awvalid) begin
        if (aw_cnt >= aw_delay) begin
          m_axil_awready = 1; aw_hs = 1; aw_cnt = 0; got_awaddr = m_axil_awaddr; aw_got = 1;
        end else begin aw_cnt++; aw_hold = 1; end
      end
      m_axil_wready = 0; w_hs = 0; w_hold = 0;
      if (m_axil_wvalid) begin
        if (w_cnt >= w_delay) begin
          m_axil_wready = 1; w_hs = 1; w_cnt = 0;
          got_wdata = m_axil_wdata; got_wstrb = m_axil_wstrb; w_got = 1;
        end else begin w_cnt++; w_hold = 1; end
      end
      if (aw_got && w_got) begin
        smem[got_awaddr] = merge(s_read(got_awaddr), got_wdata, got_wstrb);
        last_awaddr = got_awaddr; last_wdata = got_wdata; last_wstrb = got_wstrb;
        aw_got = 0; w_got = 0; pend_b++;
      end
      m_axil_arready = 0; ar_hs = 0; ar_hold = 0;
      if (m_axil_arvalid) begin
        if (ar_cnt >= ar_delay) begin
          m_axil_arready = 1; ar_hs = 1; ar_cnt = 0; rq.push_back(m_axil_araddr);
        end else begin ar_cnt++; ar_hold = 1; end
      end
      if (m_axil_bvalid && m_axil_bready) begin b_hs = 1; pend_b--; b_count++; end
      if (m_axil_rvalid && m_axil_rready) begin r_hs = 1; void'(rq.pop_front()); end
    end
  end

  // ready must be a single-cycle pulse
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ready) begin
          ready_cnt++; checks++;
          if (prev_ready) begin errors++; $display("FAIL ready_pulse: got 2-cycle ready need 1-cycle"); end
        end
        prev_ready = ready;
      end else prev_ready = 0;
    end
  end

  // Drives one request from a falling edge and waits for its completion.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int lat, output logic [31:0] rd, output bit ok);
    valid = 1; addr = a; wdata = d; wstrb = s;
    lat = 0; ok = 0; rd = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (ready) begin ok = 1; rd = rdata; break; end
    end
    valid = 0; addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    if (s != 0) rmem[a] = merge(ref_read(a), d, s);
  endtask

  task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
    aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
  endtask

  task automatic test_reset();
    rst_n = 0; valid = 1; addr = $urandom; wdata = $urandom; wstrb = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b need 000000",
        {ready, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready});
    end
    checks++;
    if ({rdata, m_axil_awaddr, m_axil_araddr, m_axil_wdata, m_axil_wstrb} !== '0) begin
      errors++; $display("FAIL reset_regs: got rdata=%h awaddr=%h wdata=%h need 0", rdata, m_axil_awaddr, m_axil_wdata);
    end
    valid = 0;
    @(negedge clk); rst_n = 1; @(negedge clk);
  endtask

  task automatic test_write_basic();
    int lat; logic [31:0] rd; bit ok;
    set_delays(0, 0, 0, 0, 0); bresp_cfg = 0;
    do_req(32'h10, 32'hDEADBEEF, 4'hF, lat, rd, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_basic_done: got timeout need ready"); end
    checks++; if (lat != 3) begin errors++; $display("FAIL wr_basic_latency: got %0d need 3", lat); end
    checks++; if (last_awaddr !== 32'h10) begin errors++; $display("FAIL wr_basic_awaddr: got %h need 00000010", last_awaddr); end
    checks++; if (last_wdata !== 32'hDEADBEEF || last_wstrb !== 4'hF) begin
      errors++; $display("FAIL wr_basic_wdata: got %h/%h need deadbeef/f", last_wdata, last_wstrb); end
    checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL wr_basic_rdata_kept: got %h need %h", rd, exp_rdata); end
  endtask

  task automatic test_read_stall();
    int lat; logic [31:0] rd; bit ok;
    smem[32'h20] = 32'h12345678; rmem[32'h20] = 32'h12345678;
    set_delays(0, 0, 0, 3, 0);
    @(negedge clk);
    do_req(32'h20, $urandom, 4'h0, lat, rd, ok);
    exp_rdata = 32'h12345678;
    checks++; if (!ok) begin errors++; $display("FAIL rd_stall_done: got timeout need ready"); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rd_stall_data: got %h need 12345678", rd); end
    checks++; if (lat != 6) begin errors++; $display("FAIL rd_stall_latency: got %0d need 6", lat); end
  endtask

  task automatic test_w_late();
    int lat, b0; logic [31:0] rd, d; bit ok;
    set_delays(0, 4, 0, 0, 0);
    d = $urandom; b0 = b_count;
    @(negedge clk);
    do_req(32'h44, d, 4'b0110, lat, rd, ok);
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL w_late_done: got timeout need ready"); end
    checks++; if (b_count - b0 != 1) begin errors++; $display("FAIL w_late_bcount: got %0d need 1", b_count - b0); end
    checks++; if (lat != 7) begin errors++; $display("FAIL w_late_latency: got %0d need 7", lat); end
    checks++; if (last_wdata !== d || last_wstrb !== 4'b0110) begin
      errors++; $display("FAIL w_late_wdata: got %h/%h need %h/6", last_wdata, last_wstrb, d); end
  endtask

  task automatic test_bresp_err();
    int lat, r0; logic [31:0] rd, d; bit ok;
    set_delays(1, 0, 2, 0, 1); bresp_cfg = 2'b10;
    d = $urandom; r0 = ready_cnt;
    @(negedge clk);
    do_req(32'h30, d, 4'hF, lat, rd, ok);
    @(negedge clk);
    checks++; if (!ok || ready_cnt - r0 != 1) begin
      errors++; $display("FAIL bresp_err_ready: got %0d pulses need 1", ready_cnt - r0); end
    bresp_cfg = 2'b00;
    do_req(32'h30, $urandom, 4'h0, lat, rd, ok);
    exp_rdata = d;
    checks++; if (!ok || rd !== d) begin errors++; $display("FAIL bresp_err_readback: got %h need %h", rd, d); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, r0; logic [31:0] rd1, rd2, d; bit ok1, ok2;
    set_delays(0, 0, 0, 0, 0);
    d = $urandom; r0 = ready_cnt;
    @(negedge clk);
    do_req(32'h58, d, 4'hF, lat1, rd1, ok1);
    do_req(32'h58, $urandom, 4'h0, lat2, rd2, ok2);
    exp_rdata = d;
    @(negedge clk);
    checks++; if (!ok1 || !ok2 || ready_cnt - r0 != 2) begin
      errors++; $display("FAIL b2b_pulses: got %0d need 2", ready_cnt - r0); end
    checks++; if (rd2 !== d) begin errors++; $display("FAIL b2b_readback: got %h need %h", rd2, d); end
    checks++; if (lat2 != 4) begin errors++; $display("FAIL b2b_latency: got %0d need 4", lat2); end
  endtask

  task automatic test_reset_mid();
    int lat, r0; logic [31:0] rd, e; bit ok, seen;
    set_delays(0, 0, 0, 0, 10);
    @(negedge clk);
    r0 = ready_cnt; seen = 0;
    valid = 1; addr = 32'h20; wdata = $urandom; wstrb = 4'h0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_axil_rready) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_reach_rresp: got timeout need rready"); end
    valid = 0; rst_n = 0;
    #1;
    checks++;
    if ({ready, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready} !== 6'b0 ||
        rdata !== '0 || m_axil_araddr !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got ctrl=%b rdata=%h araddr=%h need 0",
        {ready, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready}, rdata, m_axil_araddr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++; if (ready_cnt != r0) begin errors++; $display("FAIL rst_mid_no_ready: got %0d pulses need 0", ready_cnt - r0); end
    exp_rdata = '0;
    set_delays(0, 0, 0, 1, 1);
    e = ref_read(32'h20);
    do_req(32'h20, $urandom, 4'h0, lat, rd, ok);
    exp_rdata = e;
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL rst_mid_next_read: got %h need %h", rd, e); end
  endtask

  task automatic test_random();
    int lat, r0, n; logic [31:0] rd, a, d, e; logic [3:0] s; bit ok;
    n = 40; r0 = ready_cnt;
    for (int i = 0; i < n; i++) begin
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      bresp_cfg = 2'($urandom); rresp_cfg = 2'($urandom);
      a = {26'd0, 4'($urandom), 2'b00};
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      e = (s == 0) ? ref_read(a) : exp_rdata;
      do_req(a, d, s, lat, rd, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_done[%0d]: got timeout need ready", i); end
      checks++; if (rd !== e) begin errors++; $display("FAIL rand_rdata[%0d]: got %h need %h", i, rd, e); end
      if (s != 0) begin
        checks++; if (last_awaddr !== a) begin errors++; $display("FAIL rand_awaddr[%0d]: got %h need %h", i, last_awaddr, a); end
      end
      exp_rdata = e;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    checks++; if (ready_cnt - r0 != n) begin errors++; $display("FAIL rand_pulses: got %0d need %0d", ready_cnt - r0, n); end
    rresp_cfg = 2'b00; bresp_cfg = 2'b00;
  endtask

  initial begin
    valid = 0; addr = '0; wdata = '0; wstrb = '0; rst_n = 0;
    @(negedge clk);
    test_reset();
    test_write_basic();
    test_read_stall();
    test_w_late();
    test_bresp_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish need finish");
    $fatal(1, "timeout");
  end

endmodule
